// File: rtl/czono_ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : czono_ram_loader                                             |
// | Description : Streams a constrained zonotope (c, G, A, b) from a valid/    |
// |               ready word stream into four RAM write ports.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module czono_ram_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX       = 10,
  parameter int NGMAX      = 5,
  parameter int NCMAX      = 3,
  parameter int AW_N       = $clog2(NMAX) + 1,
  parameter int AW_G       = $clog2(NGMAX) + 1,
  parameter int AW_C       = $clog2(NCMAX) + 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [31:0]           n_i,
  input  logic [31:0]           ng_i,
  input  logic [31:0]           nc_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  c_we,
  output logic [AW_N-1:0]       c_addr,
  output logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  G_we,
  output logic [AW_N-1:0]       G_raddr,
  output logic [AW_G-1:0]       G_caddr,
  output logic [DATA_WIDTH-1:0] G_wdata,
  output logic                  A_we,
  output logic [AW_C-1:0]       A_raddr,
  output logic [AW_G-1:0]       A_caddr,
  output logic [DATA_WIDTH-1:0] A_wdata,
  output logic                  b_we,
  output logic [AW_C-1:0]       b_addr,
  output logic [DATA_WIDTH-1:0] b_wdata,
  output logic [31:0]           n_o,
  output logic [31:0]           ng_o,
  output logic [31:0]           nc_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // One row counter serves both the n-indexed and nc-indexed sections.
  localparam int RW = (AW_N > AW_C) ? AW_N : AW_C;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_C = 3'd1;
  localparam logic [2:0] S_LOAD_G = 3'd2;
  localparam logic [2:0] S_LOAD_A = 3'd3;
  localparam logic [2:0] S_LOAD_B = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [RW-1:0]   row;
  logic [AW_G-1:0] col;
  logic [31:0]     n_q;
  logic [31:0]     ng_q;
  logic [31:0]     nc_q;
  logic [31:0]     row_ext;
  logic [31:0]     col_ext;
  logic            fire;
  logic            dims_ok;
  logic            row_last_n;
  logic            row_last_c;
  logic            col_last;

  assign fire    = s_valid_i && s_ready_o;
  assign dims_ok = (n_i >= 32'd1) && (n_i <= 32'(NMAX)) &&
                   (ng_i <= 32'(NGMAX)) && (nc_i <= 32'(NCMAX));

  assign row_ext    = {{(32-RW){1'b0}}, row};
  assign col_ext    = {{(32-AW_G){1'b0}}, col};
  assign row_last_n = (row_ext == n_q - 32'd1);
  assign row_last_c = (row_ext == nc_q - 32'd1);
  assign col_last   = (col_ext == ng_q - 32'd1);

  assign n_o  = n_q;
  assign ng_o = ng_q;
  assign nc_o = nc_q;

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: each section advances on its last accepted beat, skipping empty sections.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i && dims_ok) state_nxt = S_LOAD_C;
      S_LOAD_C: if (fire && row_last_n) begin
                  if (ng_q != 32'd0)      state_nxt = S_LOAD_G;
                  else if (nc_q != 32'd0) state_nxt = S_LOAD_B;
                  else                    state_nxt = S_FINISH;
                end
      S_LOAD_G: if (fire && col_last && row_last_n)
                  state_nxt = (nc_q != 32'd0) ? S_LOAD_A : S_FINISH;
      S_LOAD_A: if (fire && col_last && row_last_c) state_nxt = S_LOAD_B;
      S_LOAD_B: if (fire && row_last_c) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: stream is accepted only while a section is loading.
  always_comb begin
    s_ready_o = 1'b0;
    busy_o    = (state != S_IDLE);
    case (state)
      S_LOAD_C, S_LOAD_G, S_LOAD_A, S_LOAD_B: s_ready_o = 1'b1;
      default:                                s_ready_o = 1'b0;
    endcase
  end

  // Row/column counters; they only move on an accepted beat so stream gaps stall them.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      row <= '0;
      col <= '0;
    end else if (fire) begin
      case (state)
        S_LOAD_C: row <= row_last_n ? '0 : row + 1'b1;
        S_LOAD_G: begin
          if (col_last) begin
            col <= '0;
            row <= row_last_n ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_LOAD_A: begin
          if (col_last) begin
            col <= '0;
            row <= row_last_c ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_LOAD_B: row <= row_last_c ? '0 : row + 1'b1;
        default: ;
      endcase
    end
  end

  // Registered RAM write ports: each accepted beat becomes one write in the next cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      c_we    <= 1'b0; c_addr  <= '0; c_wdata <= '0;
      G_we    <= 1'b0; G_raddr <= '0; G_caddr <= '0; G_wdata <= '0;
      A_we    <= 1'b0; A_raddr <= '0; A_caddr <= '0; A_wdata <= '0;
      b_we    <= 1'b0; b_addr  <= '0; b_wdata <= '0;
    end else begin
      c_we <= 1'b0;
      G_we <= 1'b0;
      A_we <= 1'b0;
      b_we <= 1'b0;
      if (fire) begin
        case (state)
          S_LOAD_C: begin
            c_we <= 1'b1; c_addr <= row[AW_N-1:0]; c_wdata <= s_data_i;
          end
          S_LOAD_G: begin
            G_we <= 1'b1; G_raddr <= row[AW_N-1:0]; G_caddr <= col; G_wdata <= s_data_i;
          end
          S_LOAD_A: begin
            A_we <= 1'b1; A_raddr <= row[AW_C-1:0]; A_caddr <= col; A_wdata <= s_data_i;
          end
          S_LOAD_B: begin
            b_we <= 1'b1; b_addr <= row[AW_C-1:0]; b_wdata <= s_data_i;
          end
          default: ;
        endcase
      end
    end
  end

  // Dimension latch: captured only on an accepted start, untouched on a rejected one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      n_q  <= '0;
      ng_q <= '0;
      nc_q <= '0;
    end else if (state == S_IDLE && start_i && dims_ok) begin
      n_q  <= n_i;
      ng_q <= ng_i;
      nc_q <= nc_i;
    end
  end

  // Status pulses: done follows the FINISH cycle, err follows a rejected start.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      done_o <= (state == S_FINISH);
      err_o  <= (state == S_IDLE) && start_i && !dims_ok;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_czono_ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_czono_ram_loader                                          |
// | Description : Scoreboard bench for czono_ram_loader with a stream-order    |
// |               reference model and randomized loads.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_czono_ram_loader;
  localparam int DW    = 32;
  localparam int NMAX  = 10;
  localparam int NGMAX = 5;
  localparam int NCMAX = 3;
  localparam int AW_N  = $clog2(NMAX) + 1;
  localparam int AW_G  = $clog2(NGMAX) + 1;
  localparam int AW_C  = $clog2(NCMAX) + 1;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0;
  logic [31:0] n_i = '0, ng_i = '0, nc_i = '0;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready_o;
  logic c_we, G_we, A_we, b_we;
  logic [AW_N-1:0] c_addr, G_raddr;
  logic [AW_G-1:0] G_caddr, A_caddr;
  logic [AW_C-1:0] A_raddr, b_addr;
  logic [DW-1:0] c_wdata, G_wdata, A_wdata, b_wdata;
  logic [31:0] n_o, ng_o, nc_o;
  logic busy_o, done_o, err_o;

  czono_ram_loader #(.DATA_WIDTH(DW), .NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start),
    .n_i(n_i), .ng_i(ng_i), .nc_i(nc_i),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready_o),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .G_we(G_we), .G_raddr(G_raddr), .G_caddr(G_caddr), .G_wdata(G_wdata),
    .A_we(A_we), .A_raddr(A_raddr), .A_caddr(A_caddr), .A_wdata(A_wdata),
    .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .n_o(n_o), .ng_o(ng_o), .nc_o(nc_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // One expected RAM write: ram 0=c, 1=G, 2=A, 3=b.
  typedef struct {
    int          ram;
    int          r;
    int          c;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t plan[$];
  int  tests = 0;
  int  fails = 0;
  int  n_wr[4];
  int  done_cnt = 0;
  int  err_cnt = 0;
  logic [31:0] c_mem[NMAX];
  logic [31:0] g_mem[NMAX][NGMAX];
  logic [31:0] a_mem[NCMAX][NGMAX];
  logic [31:0] b_mem[NCMAX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input int ram, input int r, input int c, input logic [31:0] d);
    wr_t e;
    e.ram = ram; e.r = r; e.c = c; e.d = d;
    return e;
  endfunction

  task automatic take(input int ram, input int r, input int c, input logic [31:0] d);
    wr_t e;
    n_wr[ram]++;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_write: got ram %0d row %0d col %0d data %0h, expected none", ram, r, c, d);
    end else begin
      e = exp_q.pop_front();
      check("wr_ram", ram, e.ram);
      check("wr_row", r, e.r);
      if (ram == 1 || ram == 2) check("wr_col", c, e.c);
      check("wr_data", d, e.d);
    end
    case (ram)
      0: if (r < NMAX) c_mem[r] = d;
      1: if (r < NMAX && c < NGMAX) g_mem[r][c] = d;
      2: if (r < NCMAX && c < NGMAX) a_mem[r][c] = d;
      default: if (r < NCMAX) b_mem[r] = d;
    endcase
  endtask

  // Monitor: every presented write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if ($countones({c_we, G_we, A_we, b_we}) > 1)
      check("we_onehot", $countones({c_we, G_we, A_we, b_we}), 1);
    if (c_we) take(0, int'(c_addr), 0, c_wdata);
    if (G_we) take(1, int'(G_raddr), int'(G_caddr), G_wdata);
    if (A_we) take(2, int'(A_raddr), int'(A_caddr), A_wdata);
    if (b_we) take(3, int'(b_addr), 0, b_wdata);
    if (done_o) begin
      done_cnt++;
      check("done_busy_low", busy_o, 0);
    end
    if (err_o) err_cnt++;
  end

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) n_wr[i] = 0;
    for (int i = 0; i < NMAX; i++) begin
      c_mem[i] = 32'hdeadbeef;
      for (int j = 0; j < NGMAX; j++) g_mem[i][j] = 32'hdeadbeef;
    end
    for (int k = 0; k < NCMAX; k++) begin
      b_mem[k] = 32'hdeadbeef;
      for (int j = 0; j < NGMAX; j++) a_mem[k][j] = 32'hdeadbeef;
    end
  endtask

  // Reference stream order: c, G row-major, A row-major, b.
  task automatic plan_load(input int n, input int ng, input int nc);
    plan.delete();
    for (int i = 0; i < n; i++) plan.push_back(mk(0, i, 0, $urandom));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < ng; j++) plan.push_back(mk(1, i, j, $urandom));
    for (int k = 0; k < nc; k++)
      for (int j = 0; j < ng; j++) plan.push_back(mk(2, k, j, $urandom));
    for (int k = 0; k < nc; k++) plan.push_back(mk(3, k, 0, $urandom));
  endtask

  task automatic issue_start(input int n, input int ng, input int nc);
    start = 1'b1; n_i = n; ng_i = ng; nc_i = nc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives the planned words; gap 0=none, 1=every other cycle, 2=random.
  task automatic feed(input int gap, input int start_at, input int abort_after);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < plan.size() && cyc < 4000) begin
      case (gap)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 1);
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_data = plan[idx].d;
      start = (start_at >= 0 && idx == start_at);
      if (start) begin n_i = 1; ng_i = 0; nc_i = 0; end
      @(negedge clk);
      if (s_valid && s_ready_o) begin
        exp_q.push_back(plan[idx]);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && idx == abort_after) break;
    end
    s_valid = 1'b0;
    start = 1'b0;
    if (abort_after == 0) check("feed_beats", idx, plan.size());
  endtask

  task automatic finish_check(input int n, input int ng, input int nc, input int done0);
    @(negedge clk);
    check("finish_busy", busy_o, 1);
    check("finish_done", done_o, 0);
    check("finish_ready", s_ready_o, 0);
    @(negedge clk);
    check("done_pulse", done_o, 1);
    check("done_busy", busy_o, 0);
    check("n_o", n_o, n);
    check("ng_o", ng_o, ng);
    check("nc_o", nc_o, nc);
    check("sb_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check("done_count", done_cnt - done0, 1);
    check("cnt_c", n_wr[0], n);
    check("cnt_G", n_wr[1], n * ng);
    check("cnt_A", n_wr[2], nc * ng);
    check("cnt_b", n_wr[3], nc);
  endtask

  task automatic run_load(input int n, input int ng, input int nc, input int gap, input int start_at);
    int d0;
    clear_counts();
    d0 = done_cnt;
    plan_load(n, ng, nc);
    issue_start(n, ng, nc);
    feed(gap, start_at, 0);
    finish_check(n, ng, nc, d0);
  endtask

  task automatic ref_words();
    logic [31:0] w[12];
    w = '{32'h40a00000, 32'h3f000000, 32'h3f000000, 32'h3f800000, 32'hbf000000, 32'h3f000000,
          32'h3f000000, 32'h00000000, 32'h3f000000, 32'h3f800000, 32'hbf000000, 32'h3f800000};
    plan_load(2, 3, 1);
    for (int i = 0; i < 12; i++) plan[i].d = w[i];
  endtask

  task automatic check_ref_mem();
    check("c0", c_mem[0], 32'h40a00000);
    check("c1", c_mem[1], 32'h3f000000);
    check("G00", g_mem[0][0], 32'h3f000000);
    check("G01", g_mem[0][1], 32'h3f800000);
    check("G02", g_mem[0][2], 32'hbf000000);
    check("G10", g_mem[1][0], 32'h3f000000);
    check("G11", g_mem[1][1], 32'h3f000000);
    check("G12", g_mem[1][2], 32'h00000000);
    check("A00", a_mem[0][0], 32'h3f000000);
    check("A01", a_mem[0][1], 32'h3f800000);
    check("A02", a_mem[0][2], 32'hbf000000);
    check("b0", b_mem[0], 32'h3f800000);
    check("ref_writes", n_wr[0] + n_wr[1] + n_wr[2] + n_wr[3], 12);
  endtask

  task automatic bad_start(input int n, input int ng, input int nc);
    int e0;
    int w0;
    logic [31:0] no0;
    e0 = err_cnt;
    w0 = n_wr[0] + n_wr[1] + n_wr[2] + n_wr[3];
    no0 = n_o;
    issue_start(n, ng, nc);
    @(negedge clk);
    check("err_pulse", err_o, 1);
    check("err_busy", busy_o, 0);
    check("err_ready", s_ready_o, 0);
    @(negedge clk);
    check("err_one_cycle", err_o, 0);
    @(posedge clk); #1;
    check("err_count", err_cnt - e0, 1);
    check("err_no_writes", n_wr[0] + n_wr[1] + n_wr[2] + n_wr[3], w0);
    check("err_n_kept", n_o, no0);
  endtask

  initial begin
    int d0;
    #1 rstn = 1'b0;
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_ready", s_ready_o, 0);
    check("rst_done_err", {done_o, err_o}, 0);
    check("rst_we", {c_we, G_we, A_we, b_we}, 0);
    check("rst_dims", {n_o, ng_o, nc_o}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Reference load, continuous and with alternating gaps.
    clear_counts(); d0 = done_cnt; ref_words(); issue_start(2, 3, 1); feed(0, -1, 0);
    finish_check(2, 3, 1, d0); check_ref_mem();
    clear_counts(); d0 = done_cnt; ref_words(); issue_start(2, 3, 1); feed(1, -1, 0);
    finish_check(2, 3, 1, d0); check_ref_mem();

    // Rejected starts.
    bad_start(11, 1, 1);
    bad_start(0, 1, 1);
    bad_start(2, 6, 1);
    bad_start(2, 1, 4);

    // Empty constraint section, empty generator section, extremes.
    run_load(2, 2, 0, 0, -1);
    run_load(3, 0, 2, 2, -1);
    run_load(1, 0, 0, 0, -1);
    run_load(NMAX, NGMAX, NCMAX, 2, -1);

    // Start during an active load is ignored.
    run_load(2, 3, 1, 0, 3);

    // Reset after the 5th beat aborts the load.
    clear_counts(); d0 = done_cnt;
    plan_load(3, 2, 1); issue_start(3, 2, 1); feed(0, -1, 5);
    #2 rstn = 1'b0;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_ready", s_ready_o, 0);
    check("abort_we", {c_we, G_we, A_we, b_we}, 0);
    check("abort_dims", {n_o, ng_o, nc_o}, 0);
    check("abort_pending", exp_q.size(), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("abort_no_done", done_cnt - d0, 0);
    run_load(2, 3, 1, 0, -1);

    // Randomized loads.
    for (int t = 0; t < 20; t++)
      run_load($urandom_range(1, NMAX), $urandom_range(0, NGMAX), $urandom_range(0, NCMAX),
               $urandom_range(0, 2), -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/czono_ram_loader.md
CZONO_RAM_LOADER -- requirements
Module: czono_ram_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width (IEEE-754 single).
REQ-002 SHALL have parameter NMAX, default 10, maximum state dimension n.
REQ-003 SHALL have parameter NGMAX, default 5, maximum generator count ng.
REQ-004 SHALL have parameter NCMAX, default 3, maximum constraint count nc.
REQ-005 SHALL have the ports below, with AW_N=$clog2(NMAX)+1, AW_G=$clog2(NGMAX)+1 and AW_C=$clog2(NCMAX)+1:
- clk_i  in  1  single clock; all logic on rising edge.
- rstn_i  in  1  reset, asynchronous and active-low.
- start_i  in  1  load request, sampled only in IDLE.
- n_i, ng_i, nc_i  in  32 each  dimensions of the incoming set.
- s_valid_i  in  1  stream word valid.
- s_data_i  in  DATA_WIDTH  stream word.
- s_ready_o  out  1  stream word accepted when s_valid_i && s_ready_o.
- c_we, c_addr[AW_N], c_wdata  out  center RAM write port.
- G_we, G_raddr[AW_N], G_caddr[AW_G], G_wdata  out  generator RAM write port.
- A_we, A_raddr[AW_C], A_caddr[AW_G], A_wdata  out  constraint-matrix RAM write port.
- b_we, b_addr[AW_C], b_wdata  out  constraint-vector RAM write port.
- n_o, ng_o, nc_o  out  32 each  latched dimensions, valid while busy_o=0 after a completed load.
- busy_o  out  1  high from the accepted start until done.
- done_o  out  1  one-cycle pulse at load completion.
- err_o  out  1  one-cycle pulse on rejected start.

Function
REQ-006 FSM states SHALL be IDLE, LOAD_C, LOAD_G, LOAD_A, LOAD_B, FINISH.
REQ-007 In IDLE with start_i=1, if 1<=n_i<=NMAX, ng_i<=NGMAX and nc_i<=NCMAX, the block SHALL latch the dimensions, set busy_o and enter LOAD_C.
REQ-008 In IDLE with start_i=1 and any dimension out of range, the block SHALL pulse err_o for one cycle, stay in IDLE, issue no writes and leave n_o, ng_o and nc_o unchanged.
REQ-009 Stream order SHALL be: c[0..n-1]; G row-major (row i in 0..n-1, col j in 0..ng-1); A row-major (row k in 0..nc-1, col j in 0..ng-1); b[0..nc-1].
REQ-010 Total accepted beats per load SHALL be n + n*ng + nc*ng + nc.
REQ-011 Zero-count sections SHALL be skipped without consuming beats: ng=0 skips LOAD_G and LOAD_A; nc=0 skips LOAD_A and LOAD_B.
REQ-012 s_ready_o SHALL be 1 in every LOAD_* state and 0 in IDLE and FINISH.
REQ-013 Writes SHALL be registered: a beat accepted at edge k SHALL drive exactly one *_we high during cycle k+1, with the matching address and wdata=s_data_i.
REQ-014 All *_we signals SHALL be 0 in any cycle that follows an edge with no accepted beat; a gap in s_valid_i stalls the counters and does not corrupt addresses.
REQ-015 Column counters SHALL wrap to 0 and increment the row counter when the column count reaches ng-1. The section SHALL advance after its last beat: row n-1 for G, row nc-1 for A.
REQ-016 After the final beat, the FSM SHALL enter FINISH. FINISH SHALL last one cycle, during which the final write is presented. done_o SHALL pulse in the following cycle, when busy_o drops and the FSM returns to IDLE.
REQ-017 start_i SHALL be ignored while busy_o=1.
REQ-018 Counters SHALL be AW-sized, so no address SHALL ever exceed max-1 for its dimension.

Reset
REQ-019 With rstn_i=0, and asynchronously, the state SHALL be IDLE, all counters 0 and every output 0, including n_o, ng_o and nc_o.
REQ-020 Reset in the middle of a load SHALL abort the load immediately with no further writes. RAM contents SHALL be left partial and not cleared, and done_o SHALL NOT pulse.

Verification
REQ-021 Load n=2, ng=3, nc=1 with 12 words 5.0, 0.5, 0.5, 1.0, -0.5, 0.5, 0.5, 0, 0.5, 1.0, -0.5, 1.0 -> required response:
- c[0..1]=40a00000, 3f000000;
- G rows {3f000000, 3f800000, bf000000} and {3f000000, 3f000000, 0};
- A[0]={3f000000, 3f800000, bf000000};
- b[0]=3f800000;
- one done_o pulse; n_o=2, ng_o=3, nc_o=1.
REQ-022 Same load with s_valid_i deasserted every other cycle -> identical RAM contents, and the write count stays 12.
REQ-023 start with n_i=11, or n_i=0, or ng_i=6 -> err_o pulses once, with no *_we activity and busy_o=0.
REQ-024 Load n=2, ng=2, nc=0 -> exactly 6 beats accepted; A_we and b_we never asserted; done_o pulses.
REQ-025 rstn_i low after the 5th beat -> all outputs 0 within the same cycle, no done_o, and the FSM in IDLE; a subsequent full load succeeds.
REQ-026 start_i asserted at beat 3 of an active load -> ignored; the load completes with the original dimensions.
